riscv_dmem_resp: RTL and testbench

RISCV_DMEM_RESP -- requirements
Module: riscv_dmem_resp

---
 rtl/riscv_dmem_resp.sv | 114 +++++++++++
 tb/tb_riscv_dmem_resp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_resp.sv
// Single-port data memory responder: one outstanding request, fixed request-to-response
// latency, byte-strobed writes, and an error response for misaligned or out-of-range addresses.
module riscv_dmem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        x_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] req_idx;
    logic [AW-1:0] cap_idx;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic          cap_wen;
    logic          cap_err;
    logic          req_err;
    logic          accept;

    always_comb begin
        req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= DEPTH_LIM);
        req_idx = req_addr[AW+1:2];
        accept  = req_valid && req_ready && !x_reset;
        // With LATENCY=1 the read is sampled on the acceptance edge itself.
        rd_idx  = (state == IDLE) ? req_idx : cap_idx;
        rd_word = mem[rd_idx];
    end

    // NOTE: the storage array has no reset; contents must survive x_reset, and a reset
    // branch would also stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (accept && req_wen && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wstrb[b]) mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge x_reset) begin
        if (x_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            cap_idx    <= '0;
            cap_wen    <= 1'b0;
            cap_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_idx   <= req_idx;
                        cap_wen   <= req_wen;
                        cap_err   <= req_err;
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= req_err;
                            resp_rdata <= (req_wen || req_err) ? '0 : rd_word;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= cap_err;
                        resp_rdata <= (cap_wen || cap_err) ? '0 : rd_word;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Self-checking bench for riscv_dmem_resp: directed cases plus randomized traffic against a
// word-array reference model; a second LATENCY=1 instance covers back-to-back timing.
module tb_riscv_dmem_resp;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        x_reset;
    logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_wstrb;

    logic        u1_req_valid, u1_req_ready, u1_req_wen, u1_resp_valid, u1_resp_ready, u1_resp_err;
    logic [31:0] u1_req_addr, u1_req_wdata, u1_resp_rdata;
    logic [3:0]  u1_req_wstrb;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    riscv_dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .x_reset(x_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    riscv_dmem_resp #(.DEPTH_WORDS(16), .LATENCY(1)) u1 (
        .clk(clk), .x_reset(x_reset),
        .req_valid(u1_req_valid), .req_ready(u1_req_ready), .req_addr(u1_req_addr),
        .req_wen(u1_req_wen), .req_wdata(u1_req_wdata), .req_wstrb(u1_req_wstrb),
        .resp_valid(u1_resp_valid), .resp_ready(u1_resp_ready),
        .resp_rdata(u1_resp_rdata), .resp_err(u1_resp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic model_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    endfunction

    // One full transaction: handshake, wait for response, optional back-pressure, release.
    task automatic txn(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int bp, output logic [31:0] got);
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] held_rdata;
        logic        held_err;
        int          cycles;
        int          idx;
        exp_err   = model_err(addr);
        exp_rdata = '0;
        got       = 'x;
        if (!exp_err) begin
            idx = int'(addr[31:2]);
            if (wen) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                exp_rdata = ref_mem[idx];
            end
        end
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_wen    = wen;
        req_wdata  = wdata;
        req_wstrb  = wstrb;
        resp_ready = 1'($urandom);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wen   = 1'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        cycles = 1;
        while (!resp_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("latency", 32'(cycles), 32'(LAT));
        if (!resp_valid) return;
        check("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
        check("resp_rdata", resp_rdata, exp_rdata);
        got        = resp_rdata;
        held_rdata = resp_rdata;
        held_err   = resp_err;
        resp_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'b0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, held_rdata);
            check("hold_err", {31'b0, resp_err}, {31'b0, held_err});
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("release_valid", {31'b0, resp_valid}, 32'd0);
        check("release_req_ready", {31'b0, req_ready}, 32'd1);
        resp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] w0;
        logic [31:0] addr;
        int          r;

        x_reset = 1'b1;
        {req_valid, req_wen, resp_ready} = '0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;
        {u1_req_valid, u1_req_wen, u1_resp_ready} = '0;
        u1_req_addr = '0; u1_req_wdata = '0; u1_req_wstrb = '0;
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1 x_reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) txn(32'(i * 4), 1'b1, $urandom, 4'hF, 0, got);

        txn(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, got);
        check("w10_rdata", got, 32'd0);
        txn(32'h10, 1'b0, $urandom, 4'($urandom), 0, got);
        check("r10_data", got, 32'hDEADBEEF);

        txn(32'h20, 1'b1, 32'h11223344, 4'hF, 0, got);
        txn(32'h20, 1'b1, 32'hAABBCCDD, 4'b0101, 1, got);
        txn(32'h20, 1'b0, 32'h0, 4'h0, 0, got);
        check("strobe_merge", got, 32'h11BB33DD);
        txn(32'h20, 1'b1, 32'hFFFFFFFF, 4'b0000, 0, got);
        txn(32'h20, 1'b0, 32'h0, 4'h0, 0, got);
        check("strobe_none", got, 32'h11BB33DD);

        txn(32'h22, 1'b0, 32'h0, 4'h0, 0, got);
        check("misaligned_rdata", got, 32'd0);
        w0 = ref_mem[0];
        txn(32'(DEPTH * 4), 1'b1, 32'h12345678, 4'hF, 0, got);
        txn(32'h0, 1'b0, 32'h0, 4'h0, 0, got);
        check("oob_no_alias", got, w0);

        txn(32'h10, 1'b0, 32'h0, 4'h0, 5, got);

        // Reset while the write to 0x40 is in BUSY; the write itself has already committed.
        req_valid = 1'b1; req_addr = 32'h40; req_wen = 1'b1; req_wdata = 32'h5; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ref_mem[16] = 32'h5;
        check("busy_no_valid", {31'b0, resp_valid}, 32'd0);
        check("busy_req_ready", {31'b0, req_ready}, 32'd0);
        #1 x_reset = 1'b1;
        #1;
        check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("midrst_rdata", resp_rdata, 32'd0);
        check("midrst_err", {31'b0, resp_err}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_hold_valid", {31'b0, resp_valid}, 32'd0);
        end
        x_reset = 1'b0;
        @(posedge clk); #1;
        check("postrst_no_resp", {31'b0, resp_valid}, 32'd0);
        txn(32'h40, 1'b0, 32'h0, 4'h0, 0, got);
        check("persist_40", got, 32'h5);

        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       addr = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
            else if (r == 7) addr = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
            else             addr = 32'(DEPTH * 4) + ($urandom & 32'h7FFF_FFFC);
            txn(addr, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 3)), got);
        end

        // LATENCY=1 instance: write then back-to-back reads with resp_ready tied high.
        u1_resp_ready = 1'b1;
        u1_req_valid = 1'b1; u1_req_wen = 1'b1; u1_req_addr = 32'h4;
        u1_req_wdata = 32'hCAFEF00D; u1_req_wstrb = 4'hF;
        @(posedge clk); #1;
        check("l1_wr_valid", {31'b0, u1_resp_valid}, 32'd1);
        check("l1_wr_rdata", u1_resp_rdata, 32'd0);
        check("l1_wr_err", {31'b0, u1_resp_err}, 32'd0);
        u1_req_wen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i % 2 == 0) begin
                check("l1_gap_valid", {31'b0, u1_resp_valid}, 32'd0);
                check("l1_gap_ready", {31'b0, u1_req_ready}, 32'd1);
            end else begin
                check("l1_rd_valid", {31'b0, u1_resp_valid}, 32'd1);
                check("l1_rd_rdata", u1_resp_rdata, 32'hCAFEF00D);
                check("l1_rd_ready", {31'b0, u1_req_ready}, 32'd0);
            end
        end
        u1_req_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
